// File: rtl/branch_ckpt_ctrl_pkg.sv
// branch_ckpt_ctrl_pkg: shared sizes, types and age-mask helper for the branch checkpoint controller
package branch_ckpt_ctrl_pkg;
  localparam int BS_DEPTH = 4;
  localparam int BS_TAG_W = $clog2(BS_DEPTH);
  localparam int BS_CNT_W = BS_TAG_W + 1;
  localparam int FL_PTR_W = 5;
  typedef logic [BS_TAG_W-1:0] bs_tag_t;
  typedef logic [BS_CNT_W-1:0] bs_cnt_t;
  typedef logic [FL_PTR_W-1:0] fl_ptr_t;
  typedef struct packed {
    logic    valid;
    fl_ptr_t snap;
  } ckpt_t;
  // entries at or younger than tag (age measured from head), limited to the counted window
  function automatic logic [BS_DEPTH-1:0] younger_mask(bs_tag_t head, bs_tag_t tag, bs_cnt_t count);
    younger_mask = '0;
    for (int i = 0; i < BS_DEPTH; i++)
      younger_mask[i] = bs_tag_t'(bs_tag_t'(i) - head) >= bs_tag_t'(tag - head) &&
                        {1'b0, bs_tag_t'(bs_tag_t'(i) - head)} < count;
  endfunction
endpackage

// File: rtl/branch_ckpt_ctrl.sv
// branch_ckpt_ctrl: free-list head checkpoints per in-flight branch, reclaim on resolve, recovery on mispredict
//  in : clk, reset (sync, active-high), disp_isBranch/disp_allocReg (2 slots, slot 0 older), fl_head,
//       br_resolve_valid, br_resolve_tag, br_pred_wrong
//  out: bs_tags {slot1,slot0}, bs_availSlots, bs_recov_fl_head, bs_squash_mask
//  BS_DEBUG_EN: adds bs_head, bs_tail, bs_count, bs_valid and sticky bs_protoErr
module branch_ckpt_ctrl
  import branch_ckpt_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            disp_isBranch,
  input  logic [1:0]            disp_allocReg,
  input  logic [FL_PTR_W-1:0]   fl_head,
  input  logic                  br_resolve_valid,
  input  logic [BS_TAG_W-1:0]   br_resolve_tag,
  input  logic                  br_pred_wrong,
  output logic [2*BS_TAG_W-1:0] bs_tags,
  output logic [BS_CNT_W-1:0]   bs_availSlots,
  output logic [FL_PTR_W-1:0]   bs_recov_fl_head,
  output logic [BS_DEPTH-1:0]   bs_squash_mask
`ifdef BS_DEBUG_EN
  ,
  output logic [BS_TAG_W-1:0]   bs_head,
  output logic [BS_TAG_W-1:0]   bs_tail,
  output logic [BS_CNT_W-1:0]   bs_count,
  output logic [BS_DEPTH-1:0]   bs_valid,
  output logic                  bs_protoErr
`endif
);
  ckpt_t ent [BS_DEPTH];
  bs_tag_t head, tail, head1, tag1;
  bs_cnt_t count;
  logic tag_live, mispred, g0, g1;
  logic [1:0] n_grant, n_reclaim;
  fl_ptr_t snap0, snap1;
  logic [BS_DEPTH-1:0] kill;
  assign bs_availSlots = bs_cnt_t'(BS_DEPTH) - count;
  assign tag_live = br_resolve_valid && ent[br_resolve_tag].valid;
  assign mispred = tag_live && br_pred_wrong;
  assign tag1 = tail + bs_tag_t'(disp_isBranch[0]);
  assign bs_tags = {tag1, tail};
  // a mispredict squashes everything dispatched alongside it, so nothing is granted
  assign g0 = disp_isBranch[0] && bs_availSlots != '0 && !mispred;
  assign g1 = disp_isBranch[1] && bs_availSlots > bs_cnt_t'(disp_isBranch[0]) && !mispred;
  assign n_grant = {1'b0, g0} + {1'b0, g1};
  assign snap0 = fl_head + fl_ptr_t'(disp_allocReg[0]);
  assign snap1 = snap0 + fl_ptr_t'(disp_allocReg[1]);
  assign head1 = head + 1'b1;
  // reclaim looks at pre-resolve validity; a live mispredict tag stops it before reaching the tag
  assign n_reclaim = count != '0 && !ent[head].valid ?
                     (count > bs_cnt_t'(1) && !ent[head1].valid ? 2'd2 : 2'd1) : 2'd0;
  assign bs_recov_fl_head = ent[br_resolve_tag].snap;
  assign kill = mispred ? younger_mask(head, br_resolve_tag, count) : '0;
  assign bs_squash_mask = kill;
  always_ff @(posedge clk)
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
      for (int i = 0; i < BS_DEPTH; i++) ent[i].valid <= 1'b0;
    end else begin
      head <= head + bs_tag_t'(n_reclaim);
      tail <= mispred ? br_resolve_tag : tail + bs_tag_t'(n_grant);
      count <= mispred ? {1'b0, bs_tag_t'(br_resolve_tag - head)} - bs_cnt_t'(n_reclaim)
                       : count + bs_cnt_t'(n_grant) - bs_cnt_t'(n_reclaim);
      for (int i = 0; i < BS_DEPTH; i++)
        if (kill[i] || (tag_live && br_resolve_tag == bs_tag_t'(i))) ent[i].valid <= 1'b0;
      if (g0) ent[tail] <= '{valid: 1'b1, snap: snap0};
      if (g1) ent[tag1] <= '{valid: 1'b1, snap: snap1};
    end
`ifdef BS_DEBUG_EN
  bs_cnt_t n_req;
  assign n_req = bs_cnt_t'(disp_isBranch[0]) + bs_cnt_t'(disp_isBranch[1]);
  assign bs_head = head;
  assign bs_tail = tail;
  assign bs_count = count;
  always_comb
    for (int i = 0; i < BS_DEPTH; i++) bs_valid[i] = ent[i].valid;
  always_ff @(posedge clk)
    if (reset) bs_protoErr <= 1'b0;
    else if (n_req > bs_availSlots || (br_resolve_valid && !ent[br_resolve_tag].valid)) bs_protoErr <= 1'b1;
`endif
endmodule

// File: tb/tb_branch_ckpt_ctrl.sv
// tb_branch_ckpt_ctrl: directed scenarios plus random traffic checked against a queue-based checkpoint model
module tb_branch_ckpt_ctrl;
  import branch_ckpt_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset;
  logic [1:0] disp_isBranch, disp_allocReg;
  logic [FL_PTR_W-1:0] fl_head;
  logic br_resolve_valid, br_pred_wrong;
  logic [BS_TAG_W-1:0] br_resolve_tag;
  logic [2*BS_TAG_W-1:0] bs_tags;
  logic [BS_CNT_W-1:0] bs_availSlots;
  logic [FL_PTR_W-1:0] bs_recov_fl_head;
  logic [BS_DEPTH-1:0] bs_squash_mask;
`ifdef BS_DEBUG_EN
  logic [BS_TAG_W-1:0] bs_head, bs_tail;
  logic [BS_CNT_W-1:0] bs_count;
  logic [BS_DEPTH-1:0] bs_valid;
  logic bs_protoErr;
`endif
  branch_ckpt_ctrl dut (
    .clk(clk), .reset(reset), .disp_isBranch(disp_isBranch), .disp_allocReg(disp_allocReg),
    .fl_head(fl_head), .br_resolve_valid(br_resolve_valid), .br_resolve_tag(br_resolve_tag),
    .br_pred_wrong(br_pred_wrong), .bs_tags(bs_tags), .bs_availSlots(bs_availSlots),
    .bs_recov_fl_head(bs_recov_fl_head), .bs_squash_mask(bs_squash_mask)
`ifdef BS_DEBUG_EN
    , .bs_head(bs_head), .bs_tail(bs_tail), .bs_count(bs_count), .bs_valid(bs_valid),
    .bs_protoErr(bs_protoErr)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    int tag;
    int snap;
    bit live;
  } ent_t;
  ent_t q[$];
  int m_tail = 0;
  int n_total = 0;
  int n_fail = 0;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic step(input bit rst, input logic [1:0] isb, input logic [1:0] al, input int flh,
                      input bit rv, input int rt, input bit pw);
    int pos, k, avail, exp_mask, exp_recov;
    bit hit;
    reset = rst;
    disp_isBranch = isb;
    disp_allocReg = al;
    fl_head = FL_PTR_W'(flh);
    br_resolve_valid = rv;
    br_resolve_tag = BS_TAG_W'(rt);
    br_pred_wrong = pw;
    avail = BS_DEPTH - q.size();
    pos = -1;
    exp_recov = -1;
    foreach (q[j]) if (q[j].tag == rt) begin
      exp_recov = q[j].snap;
      if (q[j].live) pos = j;
    end
    hit = rv && pos >= 0;
    exp_mask = 0;
    if (hit && pw) for (int j = pos; j < q.size(); j++) exp_mask |= 1 << q[j].tag;
    #3;
    if (!rst) begin
      chk("tag0", 32'(bs_tags[1:0]), m_tail);
      chk("tag1", 32'(bs_tags[3:2]), (m_tail + int'(isb[0])) % BS_DEPTH);
      chk("avail", 32'(bs_availSlots), avail);
      chk("mask", 32'(bs_squash_mask), exp_mask);
      if (exp_recov >= 0) chk("recov", 32'(bs_recov_fl_head), exp_recov);
    end
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_tail = 0;
    end else begin
      k = 0;
      while (k < 2 && k < q.size() && !q[k].live) k++;
      if (hit && pw) begin
        while (q.size() > pos) void'(q.pop_back());
        m_tail = rt;
      end else begin
        if (hit) q[pos].live = 1'b0;
        if (isb[0] && avail >= 1) begin
          q.push_back('{m_tail, (flh + int'(al[0])) % 32, 1'b1});
          m_tail = (m_tail + 1) % BS_DEPTH;
        end
        if (isb[1] && avail >= 1 + int'(isb[0])) begin
          q.push_back('{m_tail, (flh + int'(al[0]) + int'(al[1])) % 32, 1'b1});
          m_tail = (m_tail + 1) % BS_DEPTH;
        end
      end
      repeat (k) void'(q.pop_front());
    end
    #1;
  endtask
  initial begin
    int lv[$];
    int rt;
    bit rv, pw;
    step(1, 2'b00, 2'b00, 0, 0, 0, 0);
    step(1, 2'b00, 2'b00, 0, 0, 0, 0);
    reset = 1'b0;
    #1 chk("t1_avail", 32'(bs_availSlots), 4);
    chk("t1_mask", 32'(bs_squash_mask), 0);
`ifdef BS_DEBUG_EN
    chk("t1_valid", 32'(bs_valid), 0);
`endif
    step(0, 2'b11, 2'b11, 30, 0, 0, 0);
    chk("t2_avail", 32'(bs_availSlots), 2);
    br_resolve_tag = 2'd0;
    #1 chk("t2_snap0", 32'(bs_recov_fl_head), 31);
    br_resolve_tag = 2'd1;
    #1 chk("t2_snap1", 32'(bs_recov_fl_head), 0);
    step(1, 2'b00, 2'b00, 0, 0, 0, 0);
    step(0, 2'b11, 2'b01, 7, 0, 0, 0);
    step(0, 2'b11, 2'b10, 12, 0, 0, 0);
    chk("t3_full", 32'(bs_availSlots), 0);
    step(0, 2'b00, 2'b00, 0, 1, 1, 0);
    step(0, 2'b00, 2'b00, 0, 1, 0, 0);
    step(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t3_avail", 32'(bs_availSlots), 2);
`ifdef BS_DEBUG_EN
    chk("t3_head", 32'(bs_head), 2);
`endif
    step(0, 2'b11, 2'b11, 20, 0, 0, 0);
    chk("t4_full", 32'(bs_availSlots), 0);
    step(0, 2'b01, 2'b01, 3, 1, 3, 1);
    chk("t4_tail", 32'(bs_tags[1:0]), 3);
    chk("t4_avail", 32'(bs_availSlots), 3);
    step(0, 2'b11, 2'b00, 9, 0, 0, 0);
    step(0, 2'b01, 2'b01, 9, 0, 0, 0);
    chk("t5_full", 32'(bs_availSlots), 0);
    step(0, 2'b01, 2'b00, 4, 1, 2, 0);
    chk("t5_drop", 32'(bs_availSlots), 0);
`ifdef BS_DEBUG_EN
    chk("t5_protoErr", 32'(bs_protoErr), 1);
`endif
    step(0, 2'b00, 2'b00, 0, 0, 0, 0);
    chk("t5_reclaim", 32'(bs_availSlots), 1);
    step(1, 2'b11, 2'b11, 5, 1, 0, 1);
    reset = 1'b0;
    disp_isBranch = 2'b00;
    br_resolve_valid = 1'b1;
    br_pred_wrong = 1'b1;
    br_resolve_tag = 2'd0;
    #1 chk("t6_avail", 32'(bs_availSlots), 4);
    chk("t6_mask", 32'(bs_squash_mask), 0);
    chk("t6_tag0", 32'(bs_tags[1:0]), 0);
    for (int c = 0; c < 500; c++) begin
      lv.delete();
      foreach (q[j]) if (q[j].live) lv.push_back(q[j].tag);
      rv = $urandom_range(0, 9) < 6;
      rt = (lv.size() > 0 && $urandom_range(0, 4) != 0) ? lv[$urandom_range(0, lv.size() - 1)]
                                                         : int'($urandom_range(0, 3));
      pw = $urandom_range(0, 3) == 0;
      step($urandom_range(0, 99) == 0, 2'($urandom), 2'($urandom), int'($urandom_range(0, 31)), rv, rt, pw);
    end
    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end
endmodule
